iter_counter: RTL
=================

# iter_counter

Parametrised iteration counter used by the shift-and-add datapaths, for example BCD-to-binary conversion, to count algorithm steps and flag completion. It loads a start value, decrements once per `dec` strobe and raises a sticky done flag plus a one-cycle terminal pulse when the count reaches zero. Compared with the previous fixed 16-step counter it adds:
- width and default-count parameters;
- a runtime load value;
- an explicit state machine that blocks underflow;
- an optional auto-reload mode for back-to-back conversions.

## Interface
Parameters:
- `WIDTH`, default 5: count register width in bits.
- `INIT_VAL`, default 16: start value used when `use_load`=0. Must fit in `WIDTH` bits.
- `PASS_W`, default 8: pass counter width. Used only with `ITER_CNT_AUTORELOAD_EN`.

Ports (one clock; reset is asynchronous and active-low):
- `clk`  input  1  rising-edge clock.
- `rst`  input  1  asynchronous active-low reset; 0 = reset.
- `init`  input  1  synchronous start/restart strobe.
- `use_load`  input  1  at `init`, 1 selects `load_val` and 0 selects `INIT_VAL`.
- `load_val`  input  WIDTH  runtime start value, sampled only on an `init` cycle.
- `dec`  input  1  decrement strobe, one step per high cycle.
- `count`  output  WIDTH  current remaining count, registered.
- `z`  output  1  sticky done flag, registered.
- `tc`  output  1  one-cycle terminal-count pulse, registered.
- `busy`  output  1  high when the state is RUN; decoded from the state register.
- `passes`  output  PASS_W  completed-pass counter; present only with `ITER_CNT_AUTORELOAD_EN`.

## Operation
- States are IDLE, RUN and DONE. Encoding is 2 bits.
- Reset (`rst`=0), asynchronous:
  - state = IDLE;
  - `count` = `INIT_VAL`, reload register = `INIT_VAL`;
  - `z`=0, `tc`=0, `passes`=0.
- Effective start value V = `use_load` ? `load_val` : `INIT_VAL`.
- `init`=1 in any state:
  - `count`=V and reload register=V;
  - `z`=0, `tc`=0;
  - `passes`=0 when present;
  - state = RUN if V≠0.
- `init`=1 with V=0: state goes to DONE, `z`=1, `tc` stays 0 (no pulse).
- IDLE: `dec` is ignored. Only `init` leaves IDLE.
- RUN, `dec`=1, `count`>1: `count` decrements by 1.
- RUN, `dec`=1, `count`==1, terminal step:
  - `count`=0, `z`=1, `tc`=1;
  - state = DONE.
- DONE: `dec` is ignored. `count` stays 0 (no underflow wrap) and `z` holds 1 until `init` or reset.
- `tc` is high for exactly one cycle per terminal step; it is 0 on every other cycle.
- Simultaneous `init` and `dec`: `init` wins and the `dec` is discarded.
- Reset during RUN: immediate return to the reset values. No `tc` pulse is produced.
- Arithmetic is unsigned `WIDTH`-bit. With V=`2^WIDTH`-1, exactly V `dec` strobes reach zero.

## Timing
- All outputs are registered and update on the rising `clk` edge that samples the strobe.
- `init` at edge k: `count`=V and `busy`=1 are visible after edge k.
- The N-th `dec` after `init` with V=N: at that edge `count` becomes 0 and `z` and `tc` rise together. `tc` falls at the next edge.
- Zero-cycle latency from strobe to state, i.e. no extra pipeline stage.
- Throughput: one decrement per cycle; `dec` may be held high continuously.

## Configuration
- Macro `ITER_CNT_AUTORELOAD_EN`.
- Defined:
  - the terminal step reloads `count` from the reload register and stays in RUN;
  - `tc` pulses and `z` is set (sticky) on every terminal step;
  - `passes` increments on each terminal step and saturates at all-ones;
  - DONE is reached only via `init` with V=0.
- Undefined: one-shot behaviour as described in Operation. The `passes` port and its logic are absent.

## Structure
- Package `iter_cnt_pkg` holds:
  - the state enum typedef (IDLE/RUN/DONE) and its 2-bit width constant;
  - default constants for `WIDTH`, `INIT_VAL` and `PASS_W`.
- Single module `iter_counter`. No sub-module is warranted: the state machine, count register and reload register are tightly coupled.

## Test plan
- Reset then `init` with `use_load`=0, `INIT_VAL`=16, `dec` held high → `count` 16→1 over 15 cycles; on the 16th cycle `count`=0 and `z`=`tc`=1; `tc`=0 the next cycle; `z` stays 1; further `dec` keeps `count`=0.
- `init` with `use_load`=1, `load_val`=3, `dec` every other cycle → `tc` pulses once, at the 3rd `dec` edge; `busy` falls at that same edge.
- `init` with `load_val`=0 → state DONE, `z`=1, `tc` never asserts, `busy`=0.
- `init` and `dec` high in the same cycle while `count`=5 → `count` = V, not 4; then assert `rst`=0 mid-RUN → `count`=`INIT_VAL`, `z`=0, state IDLE asynchronously, with no clock needed.
- With `ITER_CNT_AUTORELOAD_EN`, `load_val`=2, `dec` held high for 7 cycles → `tc` at cycles 2, 4 and 6; `count` reloads to 2 after each terminal step; `passes`=3; `busy` stays 1.

Source files
------------

// File: rtl/iter_cnt_pkg.sv
// Shared types and default parameter values for iter_counter.
// The optional auto-reload feature is enabled by defining ITER_CNT_AUTORELOAD_EN.
package iter_cnt_pkg;

   localparam int STATE_W      = 2;
   localparam int WIDTH_DEF    = 5;
   localparam int INIT_VAL_DEF = 16;
   localparam int PASS_W_DEF   = 8;

   typedef enum logic [STATE_W-1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

endpackage

// File: rtl/iter_counter.sv
// Iteration counter: loads a start value, counts down on dec, flags completion.
// Define ITER_CNT_AUTORELOAD_EN to reload on each terminal step and count passes.
module iter_counter
   import iter_cnt_pkg::*;
#(
   parameter int WIDTH    = WIDTH_DEF,
   parameter int INIT_VAL = INIT_VAL_DEF,
   parameter int PASS_W   = PASS_W_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              init,
   input  logic              use_load,
   input  logic [WIDTH-1:0]  load_val,
   input  logic              dec,
   output logic [WIDTH-1:0]  count,
   output logic              z,
   output logic              tc,
   output logic              busy
`ifdef ITER_CNT_AUTORELOAD_EN
   ,
   output logic [PASS_W-1:0] passes
`endif
);

   localparam logic [WIDTH-1:0] INIT_V = WIDTH'(INIT_VAL);

   if (PASS_W < 1 || INIT_VAL < 0 || INIT_VAL > (2**WIDTH) - 1) begin : g_bad_param
      $error("iter_counter: INIT_VAL must fit in WIDTH bits and PASS_W must be positive");
   end

   state_t           state;
   state_t           state_next;
   logic [WIDTH-1:0] start_val;
   logic             step_en;
   logic             last_step;

   always_comb begin
      start_val = use_load ? load_val : INIT_V;
      // init always wins over a coincident dec
      step_en   = (state == ST_RUN) && dec && !init;
      last_step = step_en && (count == WIDTH'(1));
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      if (init) begin
         state_next = (start_val == '0) ? ST_DONE : ST_RUN;
      end else if (last_step) begin
`ifdef ITER_CNT_AUTORELOAD_EN
         state_next = ST_RUN;
`else
         state_next = ST_DONE;
`endif
      end
   end

   always_comb begin
      busy = (state == ST_RUN);
   end

`ifdef ITER_CNT_AUTORELOAD_EN
   logic [WIDTH-1:0] reload;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count  <= INIT_V;
         reload <= INIT_V;
         z      <= 1'b0;
         tc     <= 1'b0;
         passes <= '0;
      end else begin
         tc <= 1'b0;
         if (init) begin
            count  <= start_val;
            reload <= start_val;
            z      <= (start_val == '0);
            passes <= '0;
         end else if (last_step) begin
            count <= reload;
            z     <= 1'b1;
            tc    <= 1'b1;
            if (passes != '1) begin
               passes <= passes + 1'b1;
            end
         end else if (step_en) begin
            count <= count - 1'b1;
         end
      end
   end
`else
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count <= INIT_V;
         z     <= 1'b0;
         tc    <= 1'b0;
      end else begin
         tc <= 1'b0;
         if (init) begin
            count <= start_val;
            z     <= (start_val == '0);
         end else if (last_step) begin
            // count parks at zero in DONE; no wrap
            count <= '0;
            z     <= 1'b1;
            tc    <= 1'b1;
         end else if (step_en) begin
            count <= count - 1'b1;
         end
      end
   end
`endif

endmodule
